// File: rtl/message_pkg.sv
// Shared types and constants for the message sequencer. The EOL states exist
// only when MESSAGE_SEQUENCER_CRLF_EN is defined.
package message_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam int DEPTH_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_CAPTURE = 3'd0,
    ST_READ    = 3'd1,
    ST_SEND    = 3'd2,
    ST_GAP     = 3'd3
`ifdef MESSAGE_SEQUENCER_CRLF_EN
    ,
    ST_EOL_CR  = 3'd4,
    ST_EOL_LF  = 3'd5
`endif
  } msg_state_e;

`ifdef MESSAGE_SEQUENCER_CRLF_EN
  // Records which transmission the current GAP follows.
  typedef enum logic [1:0] {
    SRC_DATA = 2'd0,
    SRC_CR   = 2'd1,
    SRC_LF   = 2'd2
  } gap_src_e;
`endif

  // Pointers need one extra bit so a full buffer (ptr == depth) is representable.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/message_buf.sv
// DEPTH x 8 message buffer: one synchronous write port, one read port with a
// registered output (data valid the cycle after re).
module message_buf #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];
  logic [7:0] rdata_q;

  // No reset: contents are only reachable through pointers the sequencer resets.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/message_sequencer.sv
// Captures bytes until TERM or a full buffer, then transmits them in reverse order.
// Define MESSAGE_SEQUENCER_CRLF_EN to append CR,LF after every message.
module message_sequencer
  import message_pkg::*;
#(
  parameter int         DEPTH = DEPTH_DEFAULT,
  parameter logic [7:0] TERM  = 8'h0D
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       new_rx_data,
  output logic [7:0] tx_data,
  output logic       new_tx_data,
  input  logic       tx_busy,
  output logic       busy,
  output logic       overflow,
  output logic [2:0] state_dbg
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  // Handshake: new_rx_data is a one-cycle valid with no back-pressure; bytes
  // arriving outside CAPTURE are dropped and flagged on overflow. new_tx_data
  // is a one-cycle valid, raised only after a cycle in which tx_busy was low.

  msg_state_e    state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          new_tx_q, new_tx_d;
  logic          overflow_q, overflow_d;
  logic          buf_we, buf_re;
  logic [7:0]    buf_rdata;
  logic          gap_from_data;

`ifdef MESSAGE_SEQUENCER_CRLF_EN
  gap_src_e gap_src_q, gap_src_d;
  assign gap_from_data = (gap_src_q == SRC_DATA);
`else
  assign gap_from_data = 1'b1;
`endif

  message_buf #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (rx_data),
    .re    (buf_re),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (buf_rdata)
  );

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    tx_data_d  = tx_data_q;
    new_tx_d   = 1'b0;
    overflow_d = 1'b0;
    buf_we     = 1'b0;
    buf_re     = 1'b0;
`ifdef MESSAGE_SEQUENCER_CRLF_EN
    gap_src_d  = gap_src_q;
`endif

    if (new_rx_data && (state_q != ST_CAPTURE)) begin
      overflow_d = 1'b1;
    end

    case (state_q)
      ST_CAPTURE: begin
        if (new_rx_data) begin
          if (rx_data == TERM) begin
            if (wr_ptr_q != '0) begin
              state_d  = ST_READ;
              rd_ptr_d = wr_ptr_q - PTR_ONE;
            end else begin
`ifdef MESSAGE_SEQUENCER_CRLF_EN
              state_d = ST_EOL_CR;
`else
              state_d = ST_CAPTURE;
`endif
            end
          end else begin
            buf_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            // Filling the last slot starts readout without waiting for TERM.
            if (wr_ptr_q == PTR_LAST) begin
              state_d  = ST_READ;
              rd_ptr_d = wr_ptr_q;
            end
          end
        end
      end

      ST_READ: begin
        buf_re  = 1'b1;
        state_d = ST_SEND;
      end

      ST_SEND: begin
        if (!tx_busy) begin
          tx_data_d = buf_rdata;
          new_tx_d  = 1'b1;
          state_d   = ST_GAP;
`ifdef MESSAGE_SEQUENCER_CRLF_EN
          gap_src_d = SRC_DATA;
`endif
        end
      end

      ST_GAP: begin
        if (gap_from_data) begin
          if (rd_ptr_q != '0) begin
            rd_ptr_d = rd_ptr_q - PTR_ONE;
            state_d  = ST_READ;
          end else begin
`ifdef MESSAGE_SEQUENCER_CRLF_EN
            state_d  = ST_EOL_CR;
`else
            state_d  = ST_CAPTURE;
            wr_ptr_d = '0;
`endif
          end
        end
`ifdef MESSAGE_SEQUENCER_CRLF_EN
        else if (gap_src_q == SRC_CR) begin
          state_d = ST_EOL_LF;
        end else begin
          state_d  = ST_CAPTURE;
          wr_ptr_d = '0;
        end
`endif
      end

`ifdef MESSAGE_SEQUENCER_CRLF_EN
      ST_EOL_CR: begin
        if (!tx_busy) begin
          tx_data_d = ASCII_CR;
          new_tx_d  = 1'b1;
          state_d   = ST_GAP;
          gap_src_d = SRC_CR;
        end
      end

      ST_EOL_LF: begin
        if (!tx_busy) begin
          tx_data_d = ASCII_LF;
          new_tx_d  = 1'b1;
          state_d   = ST_GAP;
          gap_src_d = SRC_LF;
        end
      end
`endif

      default: begin
        state_d = ST_CAPTURE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CAPTURE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tx_data_q  <= '0;
      new_tx_q   <= 1'b0;
      overflow_q <= 1'b0;
`ifdef MESSAGE_SEQUENCER_CRLF_EN
      gap_src_q  <= SRC_DATA;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tx_data_q  <= tx_data_d;
      new_tx_q   <= new_tx_d;
      overflow_q <= overflow_d;
`ifdef MESSAGE_SEQUENCER_CRLF_EN
      gap_src_q  <= gap_src_d;
`endif
    end
  end

  assign tx_data     = tx_data_q;
  assign new_tx_data = new_tx_q;
  assign overflow    = overflow_q;
  assign busy        = (state_q != ST_CAPTURE);
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_message_sequencer.sv
// Directed bench for message_sequencer: a scoreboard queue holds the bytes
// expected on tx, and a negedge monitor pops and compares on every strobe.
module tb_message_sequencer;
  import message_pkg::*;

`ifdef MESSAGE_SEQUENCER_CRLF_EN
  localparam int EOL_N = 2;
`else
  localparam int EOL_N = 0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       new_rx_data;
  logic [7:0] tx_data;
  logic       new_tx_data;
  logic       tx_busy;
  logic       busy;
  logic       overflow;
  logic [2:0] state_dbg;

  logic [7:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int tx_count = 0;
  int ovf_count = 0;
  logic prev_strobe = 1'b0;
  logic prev_tx_busy = 1'b0;

  message_sequencer #(.DEPTH(8), .TERM(8'h0D)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .new_rx_data (new_rx_data),
    .tx_data     (tx_data),
    .new_tx_data (new_tx_data),
    .tx_busy     (tx_busy),
    .busy        (busy),
    .overflow    (overflow),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (new_tx_data) begin
        tx_count++;
        check("strobe_one_cycle", {31'd0, prev_strobe}, 32'd0);
        check("strobe_while_tx_busy", {31'd0, prev_tx_busy}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_tx", {24'd0, tx_data}, 32'h100);
        end else begin
          check("tx_data", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
        end
      end
      if (overflow) ovf_count++;
    end
    prev_strobe  = new_tx_data;
    prev_tx_busy = tx_busy;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick();
    rx_data     = b;
    new_rx_data = 1'b1;
    tick();
    new_rx_data = 1'b0;
  endtask

  task automatic push_eol();
`ifdef MESSAGE_SEQUENCER_CRLF_EN
    exp_q.push_back(ASCII_CR);
    exp_q.push_back(ASCII_LF);
`endif
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < max_cycles) begin
      tick();
      n++;
    end
    check({tag, "_drain"}, exp_q.size(), 32'd0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st, input int max_cycles);
    int n = 0;
    while (state_dbg !== st && n < max_cycles) begin
      tick();
      n++;
    end
    check({tag, "_reach_state"}, {29'd0, state_dbg}, {29'd0, st});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int c0;
    int o0;
    rst         = 1'b1;
    rx_data     = "k";
    new_rx_data = 1'b1;
    tx_busy     = 1'b0;

    // Reset held with a concurrent rx strobe: reset must win.
    repeat (3) tick();
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_new_tx", {31'd0, new_tx_data}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_state", {29'd0, state_dbg}, 32'(ST_CAPTURE));
    rst         = 1'b0;
    new_rx_data = 1'b0;
    tick();
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    // "abc" + TERM -> "cba" (+ CR LF)
    c0 = tx_count;
    exp_q.push_back("c");
    exp_q.push_back("b");
    exp_q.push_back("a");
    push_eol();
    send_byte("a");
    send_byte("b");
    send_byte("c");
    check("abc_busy_before_term", {31'd0, busy}, 32'd0);
    send_byte(8'h0D);
    check("abc_busy_after_term", {31'd0, busy}, 32'd1);
    wait_idle("abc", 200);
    check("abc_strobes", tx_count - c0, 32'(3 + EOL_N));

    // "12345678" with no TERM fills the buffer and starts readout.
    c0 = tx_count;
    for (int i = 8; i >= 1; i--) exp_q.push_back(8'(8'h30 + i));
    push_eol();
    for (int i = 1; i <= 7; i++) send_byte(8'(8'h30 + i));
    check("full_busy_before_8th", {31'd0, busy}, 32'd0);
    send_byte("8");
    check("full_busy_after_8th", {31'd0, busy}, 32'd1);
    wait_idle("full", 400);
    check("full_strobes", tx_count - c0, 32'(8 + EOL_N));

    // Empty message: TERM only.
    c0 = tx_count;
    push_eol();
    send_byte(8'h0D);
    repeat (2) tick();
    wait_idle("empty", 100);
    check("empty_strobes", tx_count - c0, 32'(EOL_N));

    // tx_busy held high for 20 cycles while in SEND.
    c0 = tx_count;
    tx_busy = 1'b1;
    exp_q.push_back("q");
    push_eol();
    send_byte("q");
    send_byte(8'h0D);
    wait_state("hold", ST_SEND, 20);
    repeat (20) tick();
    check("hold_no_strobe", tx_count - c0, 32'd0);
    check("hold_in_send", {29'd0, state_dbg}, 32'(ST_SEND));
    tx_busy = 1'b0;
    tick();
    check("hold_release_strobe", {31'd0, new_tx_data}, 32'd1);
    check("hold_release_data", {24'd0, tx_data}, 32'h71);
    wait_idle("hold", 100);

    // Byte arriving during SEND is dropped and flagged.
    c0 = tx_count;
    tx_busy = 1'b1;
    exp_q.push_back("n");
    exp_q.push_back("m");
    push_eol();
    send_byte("m");
    send_byte("n");
    send_byte(8'h0D);
    wait_state("ovf", ST_SEND, 20);
    o0 = ovf_count;
    send_byte("Z");
    check("ovf_pulse", {31'd0, overflow}, 32'd1);
    tick();
    check("ovf_pulse_end", {31'd0, overflow}, 32'd0);
    check("ovf_count", ovf_count - o0, 32'd1);
    tx_busy = 1'b0;
    wait_idle("ovf", 200);
    check("ovf_strobes", tx_count - c0, 32'(2 + EOL_N));

    // Reset after the second strobe of "abcd" abandons the message.
    c0 = tx_count;
    exp_q.push_back("d");
    exp_q.push_back("c");
    send_byte("a");
    send_byte("b");
    send_byte("c");
    send_byte("d");
    send_byte(8'h0D);
    begin
      int n = 0;
      while (tx_count - c0 < 2 && n < 100) begin
        tick();
        n++;
      end
    end
    check("mid_two_strobes", tx_count - c0, 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (30) tick();
    check("mid_no_more_strobes", tx_count - c0, 32'd2);
    check("mid_state", {29'd0, state_dbg}, 32'(ST_CAPTURE));
    check("mid_busy", {31'd0, busy}, 32'd0);

    // Fresh message after the abandoned one.
    c0 = tx_count;
    exp_q.push_back("x");
    push_eol();
    send_byte("x");
    send_byte(8'h0D);
    wait_idle("after_rst", 200);
    check("after_rst_strobes", tx_count - c0, 32'(1 + EOL_N));
    check("tx_data_holds", {24'd0, tx_data}, (EOL_N != 0) ? 32'h0A : 32'h78);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/message_sequencer.md
MESSAGE_SEQUENCER -- requirements
Module: message_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 8: message buffer capacity in bytes, legal range 2..16.
REQ-002 SHALL have parameter TERM, default 8'h0D: terminator byte that ends a message.
REQ-003 SHALL have port clk, input, 1: rising-edge clock.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port rx_data, input, 8: received byte.
REQ-006 SHALL have port new_rx_data, input, 1: one-cycle strobe; rx_data is valid while it is high.
REQ-007 SHALL have port tx_data, output, 8: byte to transmit.
REQ-008 SHALL have port new_tx_data, output, 1: one-cycle transmit strobe.
REQ-009 SHALL have port tx_busy, input, 1: transmitter busy; no strobe may be issued while it is high.
REQ-010 SHALL have port busy, output, 1: high in every state except CAPTURE.
REQ-011 SHALL have port overflow, output, 1: one-cycle pulse when a received byte is dropped.

Function
REQ-012 SHALL implement states CAPTURE, READ, SEND, GAP, EOL_CR and EOL_LF.
REQ-013 In CAPTURE, a non-TERM byte on new_rx_data SHALL be written to the buffer at wr_ptr, and wr_ptr SHALL increment by 1.
REQ-014 In CAPTURE, a TERM byte SHALL NOT be stored; the next state SHALL be READ with rd_ptr = wr_ptr-1, or EOL_CR if wr_ptr = 0 (empty message).
REQ-015 The write that makes wr_ptr = DEPTH SHALL move the state to READ on the next cycle, with no terminator needed.
REQ-016 Readout SHALL be in reverse order: the last stored byte first, index 0 last.
REQ-017 The buffer read SHALL have 1-cycle latency; READ SHALL present rd_ptr and always go to SEND.
REQ-018 In SEND with tx_busy low, tx_data SHALL take the buffer byte, new_tx_data SHALL be high for 1 cycle, and the next state SHALL be GAP; with tx_busy high, SEND SHALL hold.
REQ-019 GAP SHALL last exactly 1 cycle, then go to READ with rd_ptr-1, or to EOL_CR if rd_ptr was 0.
REQ-020 EOL_CR and EOL_LF SHALL send 8'h0D and then 8'h0A under the same tx_busy/strobe/GAP rules, then go to CAPTURE with wr_ptr = 0.
REQ-021 A new_rx_data strobe in any state other than CAPTURE SHALL drop the byte, pulse overflow in the following cycle, and leave the buffer unchanged.
REQ-022 tx_data SHALL hold its last sent value between strobes.
REQ-023 wr_ptr and rd_ptr SHALL be clog2(DEPTH)+1 bits wide; rd_ptr SHALL never wrap below 0.

Reset
REQ-024 While rst is high: state = CAPTURE, wr_ptr = 0, rd_ptr = 0, tx_data = 0, new_tx_data = 0, overflow = 0, busy = 0.
REQ-025 Reset mid-message SHALL abandon the message with no further strobes; buffer contents may persist but SHALL be unreachable.
REQ-026 rst SHALL take priority over new_rx_data in the same cycle.

Configuration
REQ-027 Macro MESSAGE_SEQUENCER_CRLF_EN SHALL control the line ending.
REQ-028 With MESSAGE_SEQUENCER_CRLF_EN defined: EOL_CR and EOL_LF SHALL be emitted per REQ-020.
REQ-029 Without it: EOL states SHALL not exist, the end of readout SHALL go directly to CAPTURE, and an empty message SHALL produce no strobe.

Structure
REQ-030 Package message_pkg SHALL hold the state enum typedef and the constants ASCII_CR = 8'h0D, ASCII_LF = 8'h0A and default DEPTH.
REQ-031 Sub-module message_buf SHALL be a DEPTH x 8 synchronous RAM with one write port and one registered read port.

Verification
REQ-032 Bench SHALL drive rx "abc",0x0D; tx SHALL be "c","b","a",0x0D,0x0A with exactly 5 strobes.
REQ-033 Bench SHALL drive rx "12345678" with no TERM and DEPTH = 8; tx SHALL be "87654321",0x0D,0x0A, and busy SHALL rise 1 cycle after the 8th write.
REQ-034 Bench SHALL drive rx 0x0D only; tx SHALL be 0x0D,0x0A, or nothing without the macro.
REQ-035 Bench SHALL hold tx_busy high for 20 cycles during SEND; there SHALL be no strobe during that window, and the byte SHALL be sent 1 cycle after tx_busy falls.
REQ-036 Bench SHALL strobe rx "Z" during SEND; overflow SHALL pulse once and "Z" SHALL never appear on tx.
REQ-037 Bench SHALL assert rst for 1 cycle after the 2nd tx strobe of "abcd"; there SHALL be no further strobes, and a subsequent "x",0x0D SHALL give "x",0x0D,0x0A.
